// File: rtl/alu_pkg.sv
// Shared ALU package: multiply op encodings, multiplier FSM states and
// the iteration count used by the sequential multiplier.
package alu_pkg;

    // Encoding matches funct3[1:0] of the RISC-V M-extension multiplies.
    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mul_state_e;

    localparam int unsigned MUL_ITER = 32;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on accept, multiplied unsigned one
// multiplier bit per clock, then the 64-bit result is sign-corrected and
// the requested word selected.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset; aborts any operation
//   start        request strobe, sampled only while idle
//   op           00=MUL 01=MULH 10=MULHSU 11=MULHU
//   multiplicand rs1 operand, captured on accept
//   multiplier   rs2 operand, captured on accept
//   busy         high while a multiply is in progress
//   done         one-cycle pulse when product is updated
//   product      selected result word, held until the next done
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CNT_W = $clog2(MUL_ITER) + 1;

    mul_state_e         state;
    mul_op_e            op_reg;
    logic               neg_reg;
    logic [2*XLEN-1:0]  a_reg;
    logic [XLEN-1:0]    b_reg;
    logic [2*XLEN-1:0]  acc;
    logic [CNT_W-1:0]   count;

    logic               sa;
    logic               sb;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic [2*XLEN-1:0]  acc_fixed;

    function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v,
                                                   input logic neg);
        return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    always_comb begin
        sa    = multiplicand[XLEN-1] &&
                (op == MUL_OP_MULH || op == MUL_OP_MULHSU);
        sb    = multiplier[XLEN-1] && (op == MUL_OP_MULH);
        // Magnitude of the most negative value wraps to itself, which is
        // the correct unsigned magnitude.
        a_mag = sa ? (~multiplicand + {{(XLEN-1){1'b0}}, 1'b1}) : multiplicand;
        b_mag = sb ? (~multiplier + {{(XLEN-1){1'b0}}, 1'b1}) : multiplier;
        acc_fixed = cond_neg(acc, neg_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_reg  <= MUL_OP_MUL;
            neg_reg <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_reg  <= mul_op_e'(op);
                        neg_reg <= sa ^ sb;
                        a_reg   <= {{XLEN{1'b0}}, a_mag};
                        b_reg   <= b_mag;
                        acc     <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (b_reg[0]) begin
                        acc <= acc + a_reg;
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                    if (count == CNT_W'(MUL_ITER - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    product <= (op_reg == MUL_OP_MUL) ? acc_fixed[XLEN-1:0]
                                                      : acc_fixed[2*XLEN-1:XLEN];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int unsigned checks;
    int unsigned errors;

    seq_multiplier #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion, checking latency,
    // busy duration, done width and result.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int unsigned k;
        int unsigned busy_cnt;
        start = 1'b1;
        op = o;
        multiplicand = a;
        multiplier = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (busy) busy_cnt++;
        end
        check({tag, " latency"}, k, 33);
        check({tag, " busy_cycles"}, busy_cnt, 33);
        check({tag, " product"}, product, exp);
        @(posedge clk);
        #1;
        check({tag, " done_width"}, {31'd0, done}, 32'd0);
        check({tag, " product_hold"}, product, exp);
    endtask

    initial begin
        int unsigned k;
        int unsigned dones;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", product, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_7x6",      2'b00, 32'd7,        32'd6,        32'h0000002A);
        run_op("mulhu_ff",     2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mul_ff",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_op("mulh_min",     2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulh_m1",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_op("mulhsu_m1x2",  2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        run_op("mulhsu_2xff",  2'b10, 32'h00000002, 32'hFFFFFFFF, 32'h00000001);
        run_op("mulh_m7x6",    2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF);
        run_op("mul_m7x6",     2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6);
        run_op("mulh_zero",    2'b01, 32'h00000000, 32'h80000000, 32'h00000000);

        // Busy guard: second request and operand changes mid-CALC ignored.
        start = 1'b1;
        op = 2'b00;
        multiplicand = 32'd3;
        multiplier = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        dones = 0;
        while (k < 80) begin
            if (k == 10) begin
                start = 1'b1;
                multiplicand = 32'd9;
                multiplier = 32'd9;
            end else if (k == 11) begin
                start = 1'b0;
                multiplicand = 32'hDEADBEEF;
                multiplier = 32'h12345678;
            end
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                dones++;
                check("guard latency", k, 33);
                check("guard product", product, 32'h0000000F);
            end
        end
        check("guard done_count", dones, 1);
        check("guard idle", {31'd0, busy}, 32'd0);

        // Reset mid-operation.
        start = 1'b1;
        op = 2'b00;
        multiplicand = 32'd8;
        multiplier = 32'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort product", product, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort no_done", dones, 0);
        run_op("mul_4x4", 2'b00, 32'd4, 32'd4, 32'h00000010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- 32-bit iterative shift-add multiplier for the RISC-V M extension (MUL, MULH, MULHSU, MULHU) in the ALU directory.
- It is the forward-operation counterpart of the iterative divider. It consumes one operand bit per clock and signals the result with a start/busy/done handshake.
- The ALU issues one request, stalls on busy, and captures product when done pulses.

Parameters:
- XLEN, 32, operand and result width. Only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when the block is idle (busy=0)
- op  input  2  00=MUL (low word), 01=MULH (s×s high), 10=MULHSU (s×u high), 11=MULHU (u×u high); encoding matches funct3[1:0]
- multiplicand  input  XLEN  rs1 operand, captured when start is accepted
- multiplier  input  XLEN  rs2 operand, captured when start is accepted
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse; product is valid in this cycle
- product  output  XLEN  selected result word; holds until the next done

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, product=0.
  - All internal registers are cleared.
  - Reset overrides start and aborts any multiply in progress. No done is produced for an aborted operation.
- States and transitions:
  - IDLE: busy=0. If start=1, the block accepts the request.
  - CALC: 32 iterations; busy=1.
  - FIX: 1 cycle; busy=1.
  - IDLE with done=1 for one cycle.
- Accept (edge E0, IDLE with start=1):
  - Latch op.
  - Sign flags: sa = multiplicand[31] when op is MULH or MULHSU; sb = multiplier[31] when op is MULH.
  - Load |a| and |b| (magnitude if the flag is set, otherwise raw). Clear the 64-bit accumulator and the 6-bit count.
  - Go to CALC.
- CALC (edges E1..E32), one iteration per edge:
  - If b_reg[0]=1, add the 64-bit shifted a_reg into the accumulator.
  - Shift a_reg left by 1 (64-bit) and b_reg right by 1. Increment count.
  - At count==31 the transition goes to FIX.
  - No early termination: latency is fixed regardless of operand values.
- FIX (edge E33):
  - If sa XOR sb, negate the 64-bit accumulator (two's complement).
  - product = low 32 bits for MUL, high 32 bits otherwise.
  - done=1, busy=0, state goes to IDLE.
- Latency: start sampled at E0 gives done high during the cycle after E33 (33 clocks). busy is high from after E0 through E33.
- done deasserts on the next edge. product holds its value until the next completed operation.
- start while busy=1 is ignored (no queueing). Operand changes during CALC have no effect.
- start=1 in the same cycle as done=1 (state IDLE) is accepted; back-to-back throughput is 1 op per 34 cycles.
- Arithmetic:
  - The internal accumulator is 64 bits wide; there is no overflow and no truncation before result selection.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned, which is correct.
  - Zero operands follow the normal path. The sign fix of 0 yields 0.
- MUL result is identical for all signedness combinations; only the high word depends on op.

Decomposition:
- Shared ALU package (alu_pkg):
  - mul op encodings: MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU
  - state encodings: ST_IDLE, ST_CALC, ST_FIX
  - constant MUL_ITER = 32
- No sub-module required. The 64-bit conditional negate may be a local function.

Test Plan:
- MUL, 7 × 6: start, then done exactly 33 cycles later with product=0x0000002A; busy high for those 33 cycles; done high exactly 1 cycle.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF: product=0xFFFFFFFE. Repeating with MUL gives 0x00000001.
- MULH, 0x80000000 × 0x80000000: product=0x40000000. MULH, 0xFFFFFFFF × 0xFFFFFFFF: product=0x00000000.
- MULHSU, 0xFFFFFFFF × 0x00000002: product=0xFFFFFFFF. MULHSU, 0x00000002 × 0xFFFFFFFF: product=0x00000001.
- Busy guard: start MUL 3 × 5; pulse start with 9 × 9 at cycle 10. The block ignores the second request, gives a single done with product=0x0000000F, and operand changes mid-CALC have no effect.
- Reset mid-op: assert rst at cycle 15 of CALC. Next cycle busy=0, done=0, product=0, and no done follows. A new MUL 4 × 4 afterwards returns 0x00000010 after 33 cycles.
